// File: rtl/ft64_memrsp_pkg.sv
// Shared types and constants for the ft64 Wishbone memory responder.
// Optional burst stall injection is enabled with FT64_MEMRSP_STALL_EN.
package ft64_memrsp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        ERR  = 2'd3
    } memrsp_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // Fibonacci LFSR, taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Next low nibble of a word index for a wrapping burst; only the low
    // log2(N) bits move, the rest of the index is held by the caller.
    function automatic logic [3:0] wrap_inc(input logic [3:0] lo, input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  return {lo[3:2], lo[1:0] + 2'd1};
            BTE_WRAP8:  return {lo[3], lo[2:0] + 3'd1};
            default:    return lo + 4'd1;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ft64_memrsp_ram.sv
// Single-port byte-enabled synchronous RAM with registered read port.
module ft64_memrsp_ram #(
    parameter int DBW        = 128,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DBW/8-1:0]      sel,
    input  logic [DBW-1:0]        wdata,
    output logic [DBW-1:0]        rdata
);

    logic [DBW-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DBW/8; b++) begin
                if (sel[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/ft64_wb_mem_responder.sv
// Wishbone B3 slave serving memory requests from an internal RAM (assumes DEPTH_LOG2 > 4).
// Define FT64_MEMRSP_STALL_EN to inject LFSR-driven wait beats into bursts.
module ft64_wb_mem_responder
    import ft64_memrsp_pkg::*;
#(
    parameter int          DBW        = 128,
    parameter int          AMSB       = 31,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LAT        = 3,
    parameter logic [31:0] BASE       = 32'h1000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [DBW/8-1:0] sel_i,
    input  logic [AMSB:0]    adr_i,
    input  logic [2:0]       cti_i,
    input  logic [1:0]       bte_i,
    input  logic [DBW-1:0]   dat_i,
    output logic             ack_o,
    output logic             err_o,
    output logic [DBW-1:0]   dat_o,
    output logic             busy_o
);

    localparam int              LSB       = $clog2(DBW/8);
    localparam logic [AMSB:0]   BASE_A    = (AMSB+1)'(BASE);
    localparam logic [AMSB+1:0] WIN_BYTES = (AMSB+2)'(2**(DEPTH_LOG2+LSB));

    memrsp_state_e         state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] widx_q, widx_d, widx_nxt;
    logic                  we_q, we_d;
    logic [2:0]            cti_q, cti_d;
    logic [1:0]            bte_q, bte_d;
    logic                  ack_d, err_d;
    logic                  ram_we, ram_re, stall;

    logic [AMSB:0]         req_off;
    logic                  req_oor;
    logic [DEPTH_LOG2-1:0] req_widx;

    assign req_off  = adr_i - BASE_A;
    assign req_oor  = (adr_i < BASE_A) || ({1'b0, req_off} >= WIN_BYTES);
    assign req_widx = req_off[LSB +: DEPTH_LOG2];

    assign widx_nxt = (bte_q == BTE_LINEAR) ? widx_q + 1'b1
                    : {widx_q[DEPTH_LOG2-1:4], wrap_inc(widx_q[3:0], bte_q)};

`ifdef FT64_MEMRSP_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            lfsr_q <= LFSR_SEED;
        else if (state_q == XFER && cti_q != CTI_CLASSIC)
            lfsr_q <= lfsr_next(lfsr_q);
    end
    assign stall = (cti_q != CTI_CLASSIC) && lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        we_d    = we_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    we_d   = we_i;
                    cti_d  = cti_i;
                    bte_d  = bte_i;
                    widx_d = req_widx;
                    cnt_d  = 4'(LAT);
                    if (req_oor)       state_d = ERR;
                    else if (LAT == 0) state_d = XFER;
                    else               state_d = WAIT;
                end
            end
            WAIT: begin
                if (!cyc_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = XFER;
                end
            end
            XFER: begin
                if (!cyc_i) begin
                    state_d = IDLE;
                end else if (stb_i && !stall) begin
                    ack_d  = 1'b1;
                    ram_we = we_q && !rst_i;
                    ram_re = !we_q;
                    widx_d = widx_nxt;
                    // classic cycles and end-of-burst beats both close the transfer
                    if (cti_q == CTI_CLASSIC || cti_i == CTI_EOB) state_d = IDLE;
                end
            end
            ERR: begin
                err_d   = cyc_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            we_q    <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            bte_q   <= BTE_LINEAR;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            we_q    <= we_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            ack_o   <= ack_d;
            err_o   <= err_d;
        end
    end

    assign busy_o = (state_q != IDLE);

    ft64_memrsp_ram #(
        .DBW        (DBW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (widx_q),
        .sel   (sel_i),
        .wdata (dat_i),
        .rdata (dat_o)
    );

endmodule
